// File: rtl/uart_tx.sv
// uart_tx: byte-serial UART transmitter, 8N1 framing (start, DATA_BITS LSB first, stop).
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
// All outputs are registered from the next-state decode, so tx changes on the same
// edge that enters a state and never glitches.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_t;
`endif

    state_t                 r_state, w_state;
    logic [CW-1:0]          r_cnt, w_cnt;
    logic [IW-1:0]          r_idx, w_idx;
    logic [DATA_BITS-1:0]   r_shift, w_shift;
    logic                   r_tx, w_tx;
    logic                   r_busy, w_busy;
    logic                   r_done, w_done;
    logic                   w_bit_end;
`ifdef UART_TX_PARITY_EN
    // Parity is taken at acceptance because the shift register is consumed in flight.
    logic                   r_par, w_par;
`endif

    assign w_bit_end = (r_cnt == CNT_LAST);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_shift = r_shift;
`ifdef UART_TX_PARITY_EN
        w_par   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt = '0;
                w_idx = '0;
                if (tx_start) begin
                    w_shift = tx_data;
`ifdef UART_TX_PARITY_EN
                    w_par   = ^tx_data;
`endif
                    w_state = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_cnt   = '0;
                    w_idx   = '0;
                    w_state = S_DATA;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt = '0;
                    if (r_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        w_state = S_PARITY;
`else
                        w_state = S_STOP;
`endif
                    end else begin
                        w_shift = r_shift >> 1;
                        w_idx   = r_idx + IW'(1);
                    end
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_cnt   = '0;
                    w_state = S_STOP;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    w_cnt   = '0;
                    w_state = S_DONE;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            S_DONE: begin
                w_cnt   = '0;
                w_state = S_IDLE;
            end
            default: begin
                w_cnt   = '0;
                w_state = S_IDLE;
            end
        endcase

        // Outputs follow the state being entered so they register alongside it.
        w_tx = 1'b1;
        case (w_state)
            S_START:  w_tx = 1'b0;
            S_DATA:   w_tx = w_shift[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx = w_par;
`endif
            default:  w_tx = 1'b1;
        endcase
        w_busy = (w_state != S_IDLE);
        w_done = (w_state == S_DONE);
    end

    // State and output registers; reset drops the line high at once, aborting any frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_shift <= w_shift;
            r_tx    <= w_tx;
            r_busy  <= w_busy;
            r_done  <= w_done;
`ifdef UART_TX_PARITY_EN
            r_par   <= w_par;
`endif
        end
    end

    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: frame-level model of the serial timeline plus directed byte vectors.
module tb_uart_tx;

    localparam int N  = 4;
    localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
    localparam int F       = DB + 3;
    localparam int EXP_LEN = 44;
`else
    localparam int F       = DB + 2;
    localparam int EXP_LEN = 40;
`endif
    localparam int FL = F * N;

    logic       clk = 1'b0;
    logic       reset, tx_start, tx, tx_busy, tx_done;
    logic [7:0] tx_data;
    int         total = 0;
    int         bad   = 0;
    bit         chk_on = 1'b0;

    uart_tx #(.CLKS_PER_BIT(N), .DATA_BITS(DB)) dut (
        .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
        .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    // Model: on acceptance, build the frame's bit list; then walk a cycle index
    // through FL frame cycles plus one done cycle.
    logic [15:0] fbits = '1;
    int          rem = 0;
    int          idx = 0;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem = 0;
            idx = 0;
        end else if (rem > 0) begin
            rem--;
            idx++;
        end else if (tx_start === 1'b1) begin
            fbits    = '1;
            fbits[0] = 1'b0;
            for (int i = 0; i < DB; i++) fbits[1+i] = tx_data[i];
`ifdef UART_TX_PARITY_EN
            fbits[DB+1] = ^tx_data;
`endif
            rem = FL + 1;
            idx = 0;
        end
    end

    // Per-cycle compare of all outputs against the model.
    always @(negedge clk) begin : cmp
        logic et, eb, ed;
        if (chk_on && reset === 1'b1) begin
            eb = (rem > 0);
            ed = (rem > 0) && (idx == FL);
            et = (rem > 0 && idx < FL) ? fbits[idx/N] : 1'b1;
            total++;
            if ({tx, tx_busy, tx_done} !== {et, eb, ed}) begin
                bad++;
                $display("FAIL cycle t=%0t tx/busy/done got=%b%b%b exp=%b%b%b",
                         $time, tx, tx_busy, tx_done, et, eb, ed);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Pulse tx_start for one cycle, then sample bit centres and note tx_done.
    // k counts negedges after the accepting edge (k=0 is the first START cycle).
    task automatic run_frame(input logic [7:0] d, input int chg_k, input int dup_k,
                             input bit stop_at_done, output logic [15:0] cen,
                             output int done_k, output int done_n);
        cen    = '0;
        done_k = -1;
        done_n = 0;
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        for (int k = 0; k < FL + 6; k++) begin
            @(negedge clk);
            tx_start = (k == dup_k);
            if (k == chg_k) tx_data = 8'hFF;
            if (k < FL && (k % N) == N/2) cen[k/N] = tx;
            if (tx_done === 1'b1) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
            if (stop_at_done && done_n > 0) break;
        end
        tx_start = 1'b0;
    endtask

    logic [15:0] cen;
    int          dk, dn;

    initial begin
        reset    = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        #1 reset = 1'b0;
        #1 chk("reset outs", {29'd0, tx, tx_busy, tx_done}, 32'b100);
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);
        chk("idle outs", {29'd0, tx, tx_busy, tx_done}, 32'b100);

        // 1: 0x55
        run_frame(8'h55, -1, -1, 1'b0, cen, dk, dn);
`ifndef UART_TX_PARITY_EN
        chk("t1 centres", {22'd0, cen[9:0]}, 32'b1010101010);
`endif
        chk("t1 data", {24'd0, cen[8:1]}, 32'h55);
        chk("t1 done cycle", dk, EXP_LEN);
        chk("t1 done count", dn, 1);

        // 2: 0xA3 with tx_data overwritten mid-frame
        run_frame(8'hA3, 5, -1, 1'b0, cen, dk, dn);
`ifndef UART_TX_PARITY_EN
        chk("t2 centres", {22'd0, cen[9:0]}, 32'b1101000110);
`endif
        chk("t2 data", {24'd0, cen[8:1]}, 32'hA3);
        chk("t2 stop", {31'd0, cen[F-1]}, 32'd1);

        // 3: second start in DATA ignored; restart the cycle after tx_done
        run_frame(8'h3C, -1, 2*N + 1, 1'b1, cen, dk, dn);
        chk("t3 data", {24'd0, cen[8:1]}, 32'h3C);
        chk("t3 done cycle", dk, EXP_LEN);
        run_frame(8'hC3, -1, -1, 1'b0, cen, dk, dn);
        chk("t3 b2b done cycle", dk, EXP_LEN);
        chk("t3 b2b done count", dn, 1);
        chk("t3 b2b data", {24'd0, cen[8:1]}, 32'hC3);

        // 4: async reset during data bit 3
        @(negedge clk);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (4*N + 1) @(negedge clk);
        chk("t4 pre-reset tx", {31'd0, tx}, 32'd0);
        #1 reset = 1'b0;
        #1 chk("t4 async reset outs", {29'd0, tx, tx_busy, tx_done}, 32'b100);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        run_frame(8'h5A, -1, -1, 1'b0, cen, dk, dn);
        chk("t4 clean data", {24'd0, cen[8:1]}, 32'h5A);
        chk("t4 done cycle", dk, EXP_LEN);
        chk("t4 done count", dn, 1);

        // 5: controller-style stream 0x00..0x0F
        for (int b = 0; b < 16; b++) begin
            run_frame(8'(b), -1, -1, 1'b1, cen, dk, dn);
            chk("t5 data", {24'd0, cen[8:1]}, 32'(b));
            chk("t5 done", dn, 1);
        end

`ifdef UART_TX_PARITY_EN
        // 6: parity bit
        run_frame(8'h07, -1, -1, 1'b0, cen, dk, dn);
        chk("t6 parity 07", {31'd0, cen[9]}, 32'd1);
        chk("t6 stop 07", {31'd0, cen[10]}, 32'd1);
        chk("t6 len 07", dk, 44);
        run_frame(8'h03, -1, -1, 1'b0, cen, dk, dn);
        chk("t6 parity 03", {31'd0, cen[9]}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
